// File: rtl/codec_pkg.sv
// Shared codec definitions: I2S receive FSM states, default sample width and
// the I2S one-bit data delay after each frame-sync transition.
package codec_pkg;

   localparam int CODEC_DATA_W  = 16;
   localparam int I2S_SKIP_BITS = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SKIP_L,
      ST_SHIFT_L,
      ST_WAIT_R,
      ST_SKIP_R,
      ST_SHIFT_R,
      ST_PUSH,
      ST_WAIT_L
   } rx_state_e;

endpackage

// File: rtl/codec_sync_fifo.sv
// Single-clock show-ahead word FIFO with registered occupancy and a sticky
// overflow flag; shared by the ADC and DAC paths.
module codec_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   input  logic                     clr_ovf
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      level_q;
   logic             overflow_q;
   logic             do_push, do_pop, drop;

   assign empty    = (level_q == '0);
   assign full     = (level_q == (AW+1)'(DEPTH));
   assign level    = level_q;
   assign overflow = overflow_q;
   assign rd_data  = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a full buffer can still accept.
   assign do_pop  = rd_en & ~empty;
   assign do_push = wr_en & (~full | do_pop);
   assign drop    = wr_en & full & ~do_pop;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + (AW+1)'(1);
            2'b01:   level_q <= level_q - (AW+1)'(1);
            default: level_q <= level_q;
         endcase
         if (drop)         overflow_q <= 1'b1;
         else if (clr_ovf) overflow_q <= 1'b0;
      end
   end

   // NOTE: storage is deliberately not reset; pointers and level define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/codec_adc_rx.sv
// I2S ADC receiver: synchronizes the codec serial lines into clk, deserializes
// left/right samples and queues {left, right} words in a show-ahead FIFO.
module codec_adc_rx
   import codec_pkg::*;
#(
   parameter int DATA_W     = CODEC_DATA_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          bclk,
   input  logic                          adclrc,
   input  logic                          adcdat,
   input  logic                          rd_en,
   output logic [2*DATA_W-1:0]           rd_data,
   output logic                          empty,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   input  logic                          clr_ovf
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic [1:0]        bclk_sync_q, lrc_sync_q, dat_sync_q;
   logic              bclk_prev_q, lrc_prev_q;
   logic              bclk_rise, lrc_edge, lrc_fall, bit_in;

   rx_state_e         state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] left_q, right_q;
   logic              push, shift_l, shift_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         bclk_sync_q <= '0;
         lrc_sync_q  <= '0;
         dat_sync_q  <= '0;
         bclk_prev_q <= 1'b0;
         lrc_prev_q  <= 1'b0;
      end else begin
         bclk_sync_q <= {bclk_sync_q[0], bclk};
         lrc_sync_q  <= {lrc_sync_q[0], adclrc};
         dat_sync_q  <= {dat_sync_q[0], adcdat};
         bclk_prev_q <= bclk_sync_q[1];
         if (bclk_rise) lrc_prev_q <= lrc_sync_q[1];
      end
   end

   // Frame sync is only judged at bit-clock rising edges, like the data line.
   assign bclk_rise = bclk_sync_q[1] & ~bclk_prev_q;
   assign lrc_edge  = bclk_rise & (lrc_sync_q[1] ^ lrc_prev_q);
   assign lrc_fall  = lrc_edge & ~lrc_sync_q[1];
   assign bit_in    = dat_sync_q[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   // The edge that reveals the frame-sync change is itself the first skipped bit.
   // NOTE: defaults first so no path through the case leaves a latch behind.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (lrc_fall) begin
               state_d   = ST_SKIP_L;
               bit_cnt_d = CNT_W'(1);
            end
         end
         ST_SKIP_L, ST_SKIP_R: begin
            if (bit_cnt_q == CNT_W'(I2S_SKIP_BITS)) begin
               state_d   = (state_q == ST_SKIP_L) ? ST_SHIFT_L : ST_SHIFT_R;
               bit_cnt_d = '0;
            end else if (bclk_rise) begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         ST_SHIFT_L, ST_SHIFT_R: begin
            if (lrc_edge) begin
               state_d   = ST_IDLE;
               bit_cnt_d = '0;
            end else if (bclk_rise) begin
               if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                  state_d   = (state_q == ST_SHIFT_L) ? ST_WAIT_R : ST_PUSH;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_WAIT_R: begin
            if (lrc_edge) begin
               state_d   = ST_SKIP_R;
               bit_cnt_d = CNT_W'(1);
            end
         end
         ST_PUSH: begin
            state_d = ST_WAIT_L;
         end
         ST_WAIT_L: begin
            if (lrc_edge) begin
               state_d   = ST_SKIP_L;
               bit_cnt_d = CNT_W'(1);
            end
         end
         default: begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
         end
      endcase
      if (!enable) begin
         state_d   = ST_IDLE;
         bit_cnt_d = '0;
      end
   end

   always_comb begin
      push    = 1'b0;
      shift_l = 1'b0;
      shift_r = 1'b0;
      case (state_q)
         ST_SHIFT_L: shift_l = enable & bclk_rise & ~lrc_edge;
         ST_SHIFT_R: shift_r = enable & bclk_rise & ~lrc_edge;
         ST_PUSH:    push    = 1'b1;
         default:    ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         left_q  <= '0;
         right_q <= '0;
      end else begin
         if (shift_l) left_q  <= {left_q[DATA_W-2:0], bit_in};
         if (shift_r) right_q <= {right_q[DATA_W-2:0], bit_in};
      end
   end

   codec_sync_fifo #(
      .WIDTH (2*DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (push),
      .wr_data  ({left_q, right_q}),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .empty    (empty),
      .full     (full),
      .level    (level),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
   );

endmodule

// File: tb/tb_codec_adc_rx.sv
// Directed bench for codec_adc_rx: I2S frames at bclk = clk/16, table-driven
// fill/overflow vectors plus hand-written abort, enable and reset sequences.
module tb_codec_adc_rx;

   localparam int DATA_W     = 16;
   localparam int FIFO_DEPTH = 4;
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
   localparam int SLOTS      = 20;

   typedef struct {
      logic [DATA_W-1:0]   l;
      logic [DATA_W-1:0]   r;
      logic [2*DATA_W-1:0] exp_head;
      int                  exp_level;
      logic                exp_full;
      logic                exp_ovf;
   } vec_t;

   logic                clk = 1'b0;
   logic                rst, enable, bclk, adclrc, adcdat, rd_en, clr_ovf;
   logic [2*DATA_W-1:0] rd_data;
   logic                empty, full, overflow;
   logic [LVL_W-1:0]    level;

   int   vec_cnt = 0;
   int   err_cnt = 0;
   vec_t vecs [5];

   always #10 clk = ~clk;

   codec_adc_rx #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .bclk     (bclk),
      .adclrc   (adclrc),
      .adcdat   (adcdat),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .empty    (empty),
      .full     (full),
      .level    (level),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // One bit-clock period: frame sync and data change on the falling edge.
   task automatic drive_slot(input logic lrc, input logic dat);
      bclk   = 1'b0;
      adclrc = lrc;
      adcdat = dat;
      repeat (8) @(negedge clk);
      bclk = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // Slot 0 carries a junk bit, slots 1..DATA_W the word MSB first, then junk.
   task automatic send_chan(input logic lrc, input logic [DATA_W-1:0] w,
                            input int first, input int last);
      logic dat;
      for (int j = first; j <= last; j++) begin
         if (j >= 1 && j <= DATA_W) dat = w[DATA_W-j];
         else                       dat = 1'b1;
         drive_slot(lrc, dat);
      end
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
      send_chan(1'b0, l, 0, SLOTS-1);
      send_chan(1'b1, r, 0, SLOTS-1);
   endtask

   task automatic pop();
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic seen;
      vecs[0] = '{16'h1111, 16'h2222, 32'h11112222, 1, 1'b0, 1'b0};
      vecs[1] = '{16'h3333, 16'h4444, 32'h11112222, 2, 1'b0, 1'b0};
      vecs[2] = '{16'h5555, 16'h6666, 32'h11112222, 3, 1'b0, 1'b0};
      vecs[3] = '{16'h7777, 16'h8888, 32'h11112222, 4, 1'b1, 1'b0};
      vecs[4] = '{16'h9999, 16'hAAAA, 32'h11112222, 4, 1'b1, 1'b1};

      rst = 1'b1; enable = 1'b1; bclk = 1'b0; adclrc = 1'b1; adcdat = 1'b0;
      rd_en = 1'b0; clr_ovf = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      rst = 1'b0;

      // Establish frame sync high so the first frame starts on a 1->0 change.
      send_chan(1'b1, '0, 0, 3);

      send_frame(16'h2484, 16'h2124);
      check("basic_data", rd_data, 32'h24842124);
      check("basic_level", 32'(level), 32'd1);
      check("basic_empty", 32'(empty), 32'd0);
      pop();
      check("pop_empty", 32'(empty), 32'd1);
      pop();
      check("pop_on_empty_level", 32'(level), 32'd0);
      check("pop_on_empty_flag", 32'(empty), 32'd1);

      for (int i = 0; i < 5; i++) begin
         send_frame(vecs[i].l, vecs[i].r);
         check($sformatf("vec%0d_head", i), rd_data, vecs[i].exp_head);
         check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
         check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
         check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      end

      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      @(negedge clk);
      check("clr_ovf", 32'(overflow), 32'd0);
      check("clr_ovf_level", 32'(level), 32'd4);

      // Pop in exactly the cycle the new word is pushed into a full buffer.
      seen = 1'b0;
      fork
         send_frame(16'hBBBB, 16'hCCCC);
         begin
            for (int t = 0; t < 2000 && !seen; t++) begin
               @(negedge clk);
               if (dut.push) seen = 1'b1;
            end
            if (seen) begin
               rd_en = 1'b1;
               @(negedge clk);
               rd_en = 1'b0;
            end
         end
      join
      check("full_pp_push_seen", 32'(seen), 32'd1);
      check("full_pp_level", 32'(level), 32'd4);
      check("full_pp_ovf", 32'(overflow), 32'd0);
      check("order0", rd_data, 32'h33334444); pop();
      check("order1", rd_data, 32'h55556666); pop();
      check("order2", rd_data, 32'h77778888); pop();
      check("order3", rd_data, 32'hBBBBCCCC); pop();
      check("drain_empty", 32'(empty), 32'd1);

      // Frame sync flips after only 9 left bits.
      send_chan(1'b0, 16'hFFFF, 0, 9);
      send_chan(1'b1, 16'hFFFF, 0, SLOTS-1);
      check("abort_level", 32'(level), 32'd0);
      send_frame(16'hA5A5, 16'h5A5A);
      check("after_abort_data", rd_data, 32'hA5A55A5A);
      check("after_abort_level", 32'(level), 32'd1);
      pop();

      // Disable in the middle of the right channel.
      send_chan(1'b0, 16'hDEAD, 0, SLOTS-1);
      send_chan(1'b1, 16'hBEEF, 0, 7);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      enable = 1'b1;
      send_chan(1'b1, 16'hBEEF, 8, SLOTS-1);
      check("disable_level", 32'(level), 32'd0);
      send_frame(16'h1234, 16'h5678);
      check("reenable_data", rd_data, 32'h12345678);
      check("reenable_level", 32'(level), 32'd1);

      send_frame(16'h0BAD, 16'hF00D);
      check("pre_rst_level", 32'(level), 32'd2);

      // Reset partway through a left sample.
      send_chan(1'b0, 16'hCAFE, 0, 8);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_empty", 32'(empty), 32'd1);
      check("midrst_level", 32'(level), 32'd0);
      check("midrst_ovf", 32'(overflow), 32'd0);
      send_chan(1'b0, 16'hCAFE, 9, SLOTS-1);
      send_chan(1'b1, 16'hF00D, 0, SLOTS-1);
      check("midrst_no_push", 32'(level), 32'd0);
      send_frame(16'h0001, 16'hFFFF);
      check("post_rst_data", rd_data, 32'h0001FFFF);
      check("post_rst_level", 32'(level), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
